stego_load_seq: RTL

STEGO_LOAD_SEQ -- requirements
Module: stego_load_seq

---
 rtl/stego_load_seq.sv | 164 ++++++++++++++++
 1 files changed

// File: rtl/stego_load_seq.sv
// rtl/stego_load_seq.sv - sequences size check, two BRAM loads and the embed pass
// All outputs are registered from the next-state decode, so each output reflects the current state.
module stego_load_seq #(
  parameter int REG_WIDTH = 32,
  parameter int TMO_WIDTH = 24
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 go,
  input  logic [REG_WIDTH-1:0] image_size,
  input  logic [REG_WIDTH-1:0] secret_size,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic [1:0]           err_code,
  output logic                 wr_rst_n,
  output logic                 wr_start,
  output logic                 wr_sel,
  output logic [REG_WIDTH-1:0] wr_data_size,
  input  logic                 wr_finish,
  output logic                 emb_start,
  input  logic                 emb_done
);

  typedef enum logic [2:0] {
    S_IDLE, S_CHK, S_RST_W, S_LD_IMG, S_LD_SEC, S_EMBED, S_DONE, S_ERR
  } state_t;

  localparam logic [TMO_WIDTH-1:0] WD_ONE = {{(TMO_WIDTH-1){1'b0}}, 1'b1};

  state_t                 state, state_nx;
  logic [REG_WIDTH-1:0]   img_q, img_nx, sec_q, sec_nx, size_nx;
  logic [TMO_WIDTH-1:0]   wd, wd_nx, wd_inc;
  logic                   rst_cnt, rst_cnt_nx, tgt_sec, tgt_sec_nx, sel_nx;
  logic [1:0]             code_nx;
  logic                   busy_nx, done_nx, error_nx, wr_on_nx, emb_start_nx;
  logic [REG_WIDTH+2:0]   sec_x8, img_ext;

  assign sec_x8  = {sec_q, 3'b000};
  assign img_ext = {3'b000, img_q};
  assign wd_inc  = wd + WD_ONE;

  always_comb begin
    state_nx   = state;
    img_nx     = img_q;
    sec_nx     = sec_q;
    rst_cnt_nx = 1'b0;
    tgt_sec_nx = tgt_sec;
    wd_nx      = '0;
    code_nx    = err_code;
    sel_nx     = wr_sel;
    size_nx    = wr_data_size;
    case (state)
      S_IDLE, S_DONE, S_ERR: begin
        if (go) begin
          img_nx   = image_size;
          sec_nx   = secret_size;
          code_nx  = 2'd0;
          state_nx = S_CHK;
        end
      end
      S_CHK: begin
        if (img_q == '0) begin
          state_nx = S_ERR;
          code_nx  = 2'd1;
        end else if (sec_x8 > img_ext) begin
          state_nx = S_ERR;
          code_nx  = 2'd2;
        end else begin
          state_nx   = S_RST_W;
          tgt_sec_nx = 1'b0;
          sel_nx     = 1'b0;
          size_nx    = img_q;
        end
      end
      S_RST_W: begin
        rst_cnt_nx = 1'b1;
        if (rst_cnt) begin
          rst_cnt_nx = 1'b0;
          state_nx   = tgt_sec ? S_LD_SEC : S_LD_IMG;
        end
      end
      S_LD_IMG: begin
        wd_nx = wd_inc;
        if (wr_finish) begin
          if (sec_q == '0) begin
            state_nx = S_DONE;
          end else begin
            state_nx   = S_RST_W;
            tgt_sec_nx = 1'b1;
            sel_nx     = 1'b1;
            size_nx    = sec_q;
          end
        end else if (&wd_inc) begin
          state_nx = S_ERR;
          code_nx  = 2'd3;
        end
      end
      S_LD_SEC: begin
        wd_nx = wd_inc;
        if (wr_finish) begin
          state_nx = S_EMBED;
        end else if (&wd_inc) begin
          state_nx = S_ERR;
          code_nx  = 2'd3;
        end
      end
      S_EMBED: begin
        wd_nx = wd_inc;
        if (emb_done) begin
          state_nx = S_DONE;
        end else if (&wd_inc) begin
          state_nx = S_ERR;
          code_nx  = 2'd3;
        end
      end
      default: state_nx = S_IDLE;
    endcase
    // watchdog restarts from zero on every state entry
    if (state_nx != state) wd_nx = '0;
    busy_nx      = !(state_nx inside {S_IDLE, S_DONE, S_ERR});
    done_nx      = (state_nx == S_DONE);
    error_nx     = (state_nx == S_ERR);
    wr_on_nx     = (state_nx == S_LD_IMG) || (state_nx == S_LD_SEC);
    emb_start_nx = (state_nx == S_EMBED) && (state != S_EMBED);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= S_IDLE;
      img_q        <= '0;
      sec_q        <= '0;
      wd           <= '0;
      rst_cnt      <= 1'b0;
      tgt_sec      <= 1'b0;
      busy         <= 1'b0;
      done         <= 1'b0;
      error        <= 1'b0;
      err_code     <= 2'd0;
      wr_rst_n     <= 1'b0;
      wr_start     <= 1'b0;
      wr_sel       <= 1'b0;
      wr_data_size <= '0;
      emb_start    <= 1'b0;
    end else begin
      state        <= state_nx;
      img_q        <= img_nx;
      sec_q        <= sec_nx;
      wd           <= wd_nx;
      rst_cnt      <= rst_cnt_nx;
      tgt_sec      <= tgt_sec_nx;
      busy         <= busy_nx;
      done         <= done_nx;
      error        <= error_nx;
      err_code     <= code_nx;
      wr_rst_n     <= wr_on_nx;
      wr_start     <= wr_on_nx;
      wr_sel       <= sel_nx;
      wr_data_size <= size_nx;
      emb_start    <= emb_start_nx;
    end
  end

endmodule
